// File: rtl/mux_8to1.sv
// ---------------------------------------------------------------------------
// mux_8to1
//
// Registered 8-to-1 lane selector with enable. One of eight WIDTH-bit lanes
// packed in A is chosen by s and presented on y one clock later. A low En
// forces y to zero on the next edge (never holds the old value), and y_valid
// is a registered copy of En.
//
// Parameters
//   WIDTH    bit width of one lane (A is 8*WIDTH bits, y is WIDTH bits)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous, active-low reset; clears y and y_valid at once
//   A        eight lanes, lane k = A[k*WIDTH +: WIDTH], lane 0 in the LSBs
//   s        lane select, 0..7 (all codes legal)
//   En       1 = forward selected lane, 0 = output zero
//   y        registered selected lane
//   y_valid  registered En
// ---------------------------------------------------------------------------
module mux_8to1 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*WIDTH-1:0]   A,
    input  logic [2:0]           s,
    input  logic                 En,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid
);

    // Unpack the flat bus into lanes and pick one; a disabled select yields
    // zero rather than the addressed lane.
    function automatic logic [WIDTH-1:0] lane_select(
        input logic [8*WIDTH-1:0] bus,
        input logic [2:0]         sel,
        input logic               enable
    );
        logic [WIDTH-1:0] lanes [8];
        for (int k = 0; k < 8; k++) begin
            lanes[k] = bus[k*WIDTH +: WIDTH];
        end
        if (enable) begin
            return lanes[sel];
        end
        return '0;
    endfunction

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] y_p0;
    logic             vld_p0;

    always_comb begin
        sel_data = lane_select(A, s, En);
    end

    // ---- stage p0: output register (data and valid both cleared by reset) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p0   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            y_p0   <= sel_data;
            vld_p0 <= En;
        end
    end

    assign y       = y_p0;
    assign y_valid = vld_p0;

endmodule

// File: tb/tb_mux_8to1.sv
module tb_mux_8to1;

    logic        clk;
    logic        rst_n;
    logic [7:0]  A1;
    logic [2:0]  s1;
    logic        En1;
    logic [0:0]  y1;
    logic        v1;
    logic [31:0] A4;
    logic [2:0]  s4;
    logic        En4;
    logic [3:0]  y4;
    logic        v4;

    int n_assert = 0;
    int n_fail   = 0;

    mux_8to1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(A1), .s(s1), .En(En1), .y(y1), .y_valid(v1)
    );

    mux_8to1 #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(A4), .s(s4), .En(En4), .y(y4), .y_valid(v4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lane sel of a bus of w-bit lanes, by shift-and-mask.
    function automatic logic [31:0] ref_sel(input logic [31:0] a, input int w,
                                            input int sel, input logic en);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        if (!en) return 32'd0;
        return (a >> (sel * w)) & mask;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive both DUTs at a negedge, then check one cycle later (#1 after posedge).
    task automatic step(input string tag, input logic [7:0] a1, input logic [2:0] sv1,
                        input logic e1, input logic [31:0] a4, input logic [2:0] sv4,
                        input logic e4);
        @(negedge clk);
        A1 = a1; s1 = sv1; En1 = e1;
        A4 = a4; s4 = sv4; En4 = e4;
        @(posedge clk);
        #1;
        check({tag, "_y1"}, {31'd0, y1}, ref_sel({24'd0, a1}, 1, int'(sv1), e1));
        check({tag, "_v1"}, {31'd0, v1}, {31'd0, e1});
        check({tag, "_y4"}, {28'd0, y4}, ref_sel(a4, 4, int'(sv4), e4));
        check({tag, "_v4"}, {31'd0, v4}, {31'd0, e4});
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b01011010;
        rst_n = 1'b0;
        A1 = '0; s1 = '0; En1 = 1'b0;
        A4 = '0; s4 = '0; En4 = 1'b0;
        #2;
        check("reset_y1", {31'd0, y1}, 32'd0);
        check("reset_v1", {31'd0, v1}, 32'd0);
        check("reset_y4", {28'd0, y4}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full select sweep, wide-lane sweep in parallel.
        for (int k = 0; k < 8; k++) begin
            step("sweep", pat, 3'(k), 1'b1, 32'h76543210, 3'(k), 1'b1);
        end
        // Explicit golden values for the sweep pattern's last lanes.
        check("sweep_last_y", {31'd0, y1}, 32'd0);
        check("wide_last_y", {28'd0, y4}, 32'd7);

        // Enable gating.
        step("gate0", pat, 3'd0, 1'b0, 32'h76543210, 3'd5, 1'b0);
        step("gate6off", pat, 3'd6, 1'b0, 32'h76543210, 3'd6, 1'b1);
        step("gate7on", pat, 3'd7, 1'b1, 32'h76543210, 3'd7, 1'b1);
        step("gate6on", pat, 3'd6, 1'b1, 32'h76543210, 3'd1, 1'b1);
        check("gate6on_lit", {31'd0, y1}, 32'd1);

        // Asynchronous reset mid-cycle while outputs are 1.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y1", {31'd0, y1}, 32'd0);
        check("async_rst_v1", {31'd0, v1}, 32'd0);
        check("async_rst_y4", {28'd0, y4}, 32'd0);
        A1 = 8'hFF; s1 = 3'd3; En1 = 1'b1;
        A4 = 32'hFFFFFFFF; En4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y1", {31'd0, y1}, 32'd0);
        check("rst_hold_v1", {31'd0, v1}, 32'd0);
        check("rst_hold_v4", {31'd0, v4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: toggle A[3] between edges.
        step("lat_a0", 8'h00, 3'd3, 1'b1, 32'h0, 3'd3, 1'b1);
        #2;
        A1[3] = 1'b1;
        #2;
        check("lat_between", {31'd0, y1}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_after", {31'd0, y1}, 32'd1);

        // En drop for one cycle: 1,0,1.
        step("drop_a", 8'h08, 3'd3, 1'b1, 32'h0000F000, 3'd3, 1'b1);
        step("drop_b", 8'h08, 3'd3, 1'b0, 32'h0000F000, 3'd3, 1'b0);
        step("drop_c", 8'h08, 3'd3, 1'b1, 32'h0000F000, 3'd3, 1'b1);

        // Walking one.
        for (int k = 0; k < 8; k++) begin
            step("walk_hit", 8'd1 << k, 3'(k), 1'b1, 32'hF << (4*k), 3'(k), 1'b1);
            check("walk_hit_lit", {31'd0, y1}, 32'd1);
        end
        for (int k = 0; k < 8; k++) begin
            step("walk_miss", 8'd1 << k, 3'((k + 1) % 8), 1'b1,
                 32'hF << (4*k), 3'((k + 1) % 8), 1'b1);
            check("walk_miss_lit", {31'd0, y1}, 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            step("rand", 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
                 $urandom, 3'($urandom_range(0, 7)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
